pong_score_fsm: RTL and testbench

//  Game-state controller for Pong; drives o_Game_Active consumed by the ball controller.

---
 rtl/pong_score_fsm.sv | 150 +++++++++++++++
 tb/tb_pong_score_fsm.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_score_fsm.sv
// Pong game-state controller: detects wall misses against both paddles, keeps score,
// declares the winner and serves each point. Define PONG_SERVE_DELAY_EN for a timed auto-serve.
module pong_score_fsm #(
    parameter int c_GAME_WIDTH    = 40,
    parameter int c_GAME_HEIGHT   = 30,
    parameter int c_PADDLE_HEIGHT = 6,
    parameter int c_SCORE_LIMIT   = 9,
    parameter int c_SERVE_DELAY   = 25000000
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Start,
    input  logic [5:0] i_Ball_X,
    input  logic [5:0] i_Ball_Y,
    input  logic [5:0] i_Paddle_Y_P1,
    input  logic [5:0] i_Paddle_Y_P2,
    output logic       o_Game_Active,
    output logic [3:0] o_P1_Score,
    output logic [3:0] o_P2_Score,
    output logic [1:0] o_Winner,
    output logic       o_Point_Pulse
);

    if (c_SCORE_LIMIT < 1 || c_SCORE_LIMIT > 15 || c_GAME_WIDTH < 2 || c_GAME_WIDTH > 64 ||
        c_PADDLE_HEIGHT < 1 || c_PADDLE_HEIGHT > c_GAME_HEIGHT || c_SERVE_DELAY < 1) begin : g_bad_config
        $error("pong_score_fsm: parameter out of range");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUNNING,
        S_POINT,
        S_P1_WINS,
        S_P2_WINS
    } state_t;

    localparam logic [6:0] PADDLE_H = 7'(c_PADDLE_HEIGHT);
    localparam logic [5:0] P2_COL   = 6'(c_GAME_WIDTH - 1);
    localparam logic [3:0] LIMIT    = 4'(c_SCORE_LIMIT);

    state_t     state, state_next;
    logic [3:0] p1_score, p1_next;
    logic [3:0] p2_score, p2_next;
    logic       pulse, pulse_next;
    logic       p1_hit, p2_hit, p1_miss, p2_miss;

`ifdef PONG_SERVE_DELAY_EN
    localparam int SERVE_W = (c_SERVE_DELAY > 1) ? $clog2(c_SERVE_DELAY) : 1;
    localparam logic [SERVE_W-1:0] SERVE_LAST = SERVE_W'(c_SERVE_DELAY - 1);
    logic [SERVE_W-1:0] serve_cnt, serve_cnt_next;
`endif

    // Widened to 7 bits so a paddle near row 63 cannot wrap and fake a hit at the top.
    assign p1_hit = ({1'b0, i_Ball_Y} >= {1'b0, i_Paddle_Y_P1}) &&
                    ({1'b0, i_Ball_Y} <  ({1'b0, i_Paddle_Y_P1} + PADDLE_H));
    assign p2_hit = ({1'b0, i_Ball_Y} >= {1'b0, i_Paddle_Y_P2}) &&
                    ({1'b0, i_Ball_Y} <  ({1'b0, i_Paddle_Y_P2} + PADDLE_H));
    assign p1_miss = (i_Ball_X == 6'd0)   && !p1_hit;
    assign p2_miss = (i_Ball_X == P2_COL) && !p2_hit;

    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous and
    // wins over every other update, including a miss detected in the same cycle.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            state    <= S_IDLE;
            p1_score <= '0;
            p2_score <= '0;
            pulse    <= 1'b0;
`ifdef PONG_SERVE_DELAY_EN
            serve_cnt <= '0;
`endif
        end else begin
            state    <= state_next;
            p1_score <= p1_next;
            p2_score <= p2_next;
            pulse    <= pulse_next;
`ifdef PONG_SERVE_DELAY_EN
            serve_cnt <= serve_cnt_next;
`endif
        end
    end

    // NOTE: every combinational output gets a default before the case so no latch is inferred.
    always_comb begin
        state_next = state;
        p1_next    = p1_score;
        p2_next    = p2_score;
        pulse_next = 1'b0;
`ifdef PONG_SERVE_DELAY_EN
        serve_cnt_next = serve_cnt;
`endif
        case (state)
            S_IDLE: begin
                if (i_Start) state_next = S_RUNNING;
            end
            S_RUNNING: begin
                // Leaving RUNNING on the first miss is what stops a dwelling ball double-counting.
                if (p1_miss) begin
                    if (p2_score < LIMIT) begin
                        p2_next    = p2_score + 4'd1;
                        pulse_next = 1'b1;
                    end
                    state_next = S_POINT;
`ifdef PONG_SERVE_DELAY_EN
                    serve_cnt_next = '0;
`endif
                end else if (p2_miss) begin
                    if (p1_score < LIMIT) begin
                        p1_next    = p1_score + 4'd1;
                        pulse_next = 1'b1;
                    end
                    state_next = S_POINT;
`ifdef PONG_SERVE_DELAY_EN
                    serve_cnt_next = '0;
`endif
                end
            end
            S_POINT: begin
                if (p1_score == LIMIT) begin
                    state_next = S_P1_WINS;
                end else if (p2_score == LIMIT) begin
                    state_next = S_P2_WINS;
                end else begin
`ifdef PONG_SERVE_DELAY_EN
                    if (serve_cnt == SERVE_LAST) state_next = S_RUNNING;
                    else                         serve_cnt_next = serve_cnt + 1'b1;
`else
                    if (i_Start) state_next = S_RUNNING;
`endif
                end
            end
            S_P1_WINS, S_P2_WINS: begin
                if (i_Start) begin
                    p1_next    = '0;
                    p2_next    = '0;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign o_Game_Active = (state == S_RUNNING);
    assign o_P1_Score    = p1_score;
    assign o_P2_Score    = p2_score;
    assign o_Point_Pulse = pulse;
    assign o_Winner      = (state == S_P1_WINS) ? 2'b01 :
                           (state == S_P2_WINS) ? 2'b10 : 2'b00;

endmodule

// File: tb/tb_pong_score_fsm.sv
// Self-checking bench for pong_score_fsm: directed vector table, hand-written corner
// sequences and randomized play compared against a rules-level game model.
module tb_pong_score_fsm;

    localparam int W     = 40;
    localparam int H     = 30;
    localparam int PH    = 6;
    localparam int LIMIT = 9;
    localparam int DELAY = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [5:0] bx = 6'd20, by = 6'd15, py1 = 6'd10, py2 = 6'd10;
    logic       o_Game_Active, o_Point_Pulse;
    logic [3:0] o_P1_Score, o_P2_Score;
    logic [1:0] o_Winner;

    always #5 clk = ~clk;

    pong_score_fsm #(
        .c_GAME_WIDTH   (W),
        .c_GAME_HEIGHT  (H),
        .c_PADDLE_HEIGHT(PH),
        .c_SCORE_LIMIT  (LIMIT),
        .c_SERVE_DELAY  (DELAY)
    ) dut (
        .i_Clk        (clk),
        .i_Rst_L      (rst_n),
        .i_Start      (start),
        .i_Ball_X     (bx),
        .i_Ball_Y     (by),
        .i_Paddle_Y_P1(py1),
        .i_Paddle_Y_P2(py2),
        .o_Game_Active(o_Game_Active),
        .o_P1_Score   (o_P1_Score),
        .o_P2_Score   (o_P2_Score),
        .o_Winner     (o_Winner),
        .o_Point_Pulse(o_Point_Pulse)
    );

    int    checks = 0;
    int    errors = 0;
    string tag = "reset";

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Game model: phase of play plus plain integer scores.
    typedef enum {PH_IDLE, PH_PLAY, PH_BREAK, PH_OVER} phase_e;
    phase_e m_phase = PH_IDLE;
    int     m_p1 = 0, m_p2 = 0, m_wait = 0;
    bit     m_pulse = 1'b0;

    function automatic bit covers(input int pad, input int ball);
        return (ball >= pad) && (ball < pad + PH);
    endfunction

    task automatic model_step();
        m_pulse = 1'b0;
        if (!rst_n) begin
            m_phase = PH_IDLE; m_p1 = 0; m_p2 = 0; m_wait = 0;
            return;
        end
        case (m_phase)
            PH_IDLE: if (start) m_phase = PH_PLAY;
            PH_PLAY: begin
                if (int'(bx) == 0 && !covers(int'(py1), int'(by))) begin
                    if (m_p2 < LIMIT) begin m_p2++; m_pulse = 1'b1; end
                    m_phase = PH_BREAK; m_wait = 0;
                end else if (int'(bx) == W - 1 && !covers(int'(py2), int'(by))) begin
                    if (m_p1 < LIMIT) begin m_p1++; m_pulse = 1'b1; end
                    m_phase = PH_BREAK; m_wait = 0;
                end
            end
            PH_BREAK: begin
                if (m_p1 == LIMIT || m_p2 == LIMIT) m_phase = PH_OVER;
`ifdef PONG_SERVE_DELAY_EN
                else if (m_wait == DELAY - 1) m_phase = PH_PLAY;
                else m_wait++;
`else
                else if (start) m_phase = PH_PLAY;
`endif
            end
            PH_OVER: if (start) begin m_p1 = 0; m_p2 = 0; m_phase = PH_IDLE; end
            default: m_phase = PH_IDLE;
        endcase
    endtask

    task automatic tick();
        int exp_winner;
        model_step();
        @(posedge clk);
        #1;
        exp_winner = (m_phase == PH_OVER) ? ((m_p1 == LIMIT) ? 1 : 2) : 0;
        check({tag, "/active"}, 32'(o_Game_Active), 32'(m_phase == PH_PLAY));
        check({tag, "/p1"},     32'(o_P1_Score),    32'(m_p1));
        check({tag, "/p2"},     32'(o_P2_Score),    32'(m_p2));
        check({tag, "/pulse"},  32'(o_Point_Pulse), 32'(m_pulse));
        check({tag, "/winner"}, 32'(o_Winner),      32'(exp_winner));
    endtask

    // Serve the next point with the ball parked mid-board; expect_n >= 0 checks auto-serve latency
    // counted from the clock that entered the point state (already consumed by the caller).
    task automatic serve(input int expect_n);
        int n;
        bx = 6'd20; by = 6'd15;
`ifdef PONG_SERVE_DELAY_EN
        n = 1;
        while (!o_Game_Active && n < 50) begin tick(); n++; end
        if (expect_n >= 0) check({tag, "/serve_latency"}, 32'(n - 1), 32'(expect_n));
`else
        n = expect_n;
        start = 1'b1; tick(); start = 1'b0;
`endif
        check({tag, "/served"}, 32'(o_Game_Active), 32'd1);
    endtask

    typedef struct {
        string name;
        bit    start;
        int    bx, by, py1, py2;
        bit    active;
        int    p1, p2;
        bit    pulse;
    } vec_t;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{"idle_hold",      1'b0, 20, 15, 10, 10, 1'b0, 0, 0, 1'b0};
        vecs[1] = '{"start",          1'b1, 20, 15, 10, 10, 1'b1, 0, 0, 1'b0};
        vecs[2] = '{"start_in_play",  1'b1, 20, 15, 10, 10, 1'b1, 0, 0, 1'b0};
        vecs[3] = '{"p1_save",        1'b0,  0, 12, 10, 10, 1'b1, 0, 0, 1'b0};
        vecs[4] = '{"p1_save_top",    1'b0,  0, 10, 10, 10, 1'b1, 0, 0, 1'b0};
        vecs[5] = '{"p1_save_bottom", 1'b0,  0, 15, 10, 10, 1'b1, 0, 0, 1'b0};
        vecs[6] = '{"p2_edge_hit",    1'b0, 39, 29, 10, 27, 1'b1, 0, 0, 1'b0};
        vecs[7] = '{"p1_miss",        1'b0,  0, 20, 10, 27, 1'b0, 0, 1, 1'b1};
        vecs[8] = '{"p1_dwell",       1'b0,  0, 20, 10, 27, 1'b0, 0, 1, 1'b0};

        // Reset
        rst_n = 1'b0;
        tick(); tick();
        check("reset/active", 32'(o_Game_Active), 32'd0);
        check("reset/winner", 32'(o_Winner), 32'd0);
        rst_n = 1'b1;

        // Directed vector table
        for (int i = 0; i < 9; i++) begin
            tag = vecs[i].name;
            start = vecs[i].start;
            bx = 6'(vecs[i].bx); by = 6'(vecs[i].by);
            py1 = 6'(vecs[i].py1); py2 = 6'(vecs[i].py2);
            tick();
            check({tag, "/tbl_active"}, 32'(o_Game_Active), 32'(vecs[i].active));
            check({tag, "/tbl_p1"},     32'(o_P1_Score),    32'(vecs[i].p1));
            check({tag, "/tbl_p2"},     32'(o_P2_Score),    32'(vecs[i].p2));
            check({tag, "/tbl_pulse"},  32'(o_Point_Pulse), 32'(vecs[i].pulse));
        end
        start = 1'b0;

        // Ball dwelling at column 0 must not score again while the point is pending
        tag = "dwell";
`ifdef PONG_SERVE_DELAY_EN
        for (int i = 0; i < DELAY - 2; i++) tick();
`else
        for (int i = 0; i < 100; i++) tick();
`endif
        check("dwell/p2_held", 32'(o_P2_Score), 32'd1);
        check("dwell/inactive", 32'(o_Game_Active), 32'd0);
        serve(-1);

        // Paddle near the bottom of the 6-bit range: no wrap-around hit
        tag = "p2_overflow";
        bx = 6'd39; by = 6'd2; py2 = 6'd60;
        tick();
        check("p2_overflow/p1", 32'(o_P1_Score), 32'd1);
        check("p2_overflow/pulse", 32'(o_Point_Pulse), 32'd1);
        serve(DELAY);

        // Rows just outside the P1 paddle are misses
        tag = "p1_below";
        bx = 6'd0; by = 6'd16; py1 = 6'd10;
        tick();
        check("p1_below/p2", 32'(o_P2_Score), 32'd2);
        serve(DELAY);
        tag = "p1_above";
        bx = 6'd0; by = 6'd9;
        tick();
        check("p1_above/p2", 32'(o_P2_Score), 32'd3);
        serve(DELAY);

        // Reset overrides a rally in progress
        tag = "reset_mid";
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("reset_mid/active", 32'(o_Game_Active), 32'd0);
        check("reset_mid/p1", 32'(o_P1_Score), 32'd0);
        check("reset_mid/p2", 32'(o_P2_Score), 32'd0);

        // Full match won by P1
        tag = "match";
        start = 1'b1; tick(); start = 1'b0;
        for (int k = 1; k <= LIMIT; k++) begin
            bx = 6'd39; by = 6'd2; py2 = 6'd60;
            tick();
            check("match/p1_step", 32'(o_P1_Score), 32'(k));
            if (k < LIMIT) serve(DELAY);
        end
        bx = 6'd20; by = 6'd15;
        tick();
        check("match/winner", 32'(o_Winner), 32'd1);
        check("match/p1_final", 32'(o_P1_Score), 32'(LIMIT));
        tag = "match_hold";
        bx = 6'd39; by = 6'd2;
        for (int i = 0; i < 5; i++) tick();
        check("match_hold/p1_sat", 32'(o_P1_Score), 32'(LIMIT));
        check("match_hold/winner", 32'(o_Winner), 32'd1);
        tag = "match_restart";
        start = 1'b1; tick(); start = 1'b0;
        check("match_restart/p1", 32'(o_P1_Score), 32'd0);
        check("match_restart/winner", 32'(o_Winner), 32'd0);
        check("match_restart/active", 32'(o_Game_Active), 32'd0);

        // Randomized play against the model
        tag = "random";
        for (int i = 0; i < 3000; i++) begin
            int r;
            rst_n = ($urandom_range(0, 299) != 0);
            start = ($urandom_range(0, 7) == 0);
            r = $urandom_range(0, 9);
            bx = (r < 3) ? 6'd0 : (r < 6) ? 6'(W - 1) : 6'($urandom_range(1, W - 2));
            by = 6'($urandom_range(0, H - 1));
            py1 = 6'($urandom_range(0, 63));
            py2 = 6'($urandom_range(0, 63));
            tick();
        end
        rst_n = 1'b1; start = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
